// File: rtl/trb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | trb_pkg                                                                    |
// | Shared constants and enums for the turbo decoder output packer.            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package trb_pkg;

  localparam int TRB_ST        = 8;
  localparam int TRB_OUT_W     = 512;
  localparam int TRB_BLK_BITS  = 1024;
  localparam int TRB_BLK_BYTES = TRB_BLK_BITS / TRB_ST;
  localparam int LANES         = TRB_OUT_W / TRB_ST;

  // Cause of an err_framing pulse; kept for debug visibility, not ported.
  typedef enum logic [1:0] {
    NO_SOP    = 2'd0,
    OVERFLOW  = 2'd1,
    EARLY_SOP = 2'd2
  } err_cause_e;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_PACK = 1'b1
  } pack_state_e;

endpackage
`default_nettype wire

// File: rtl/trb_out_fifo2.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | trb_out_fifo2                                                              |
// | Two-entry registered FIFO; the head entry drives dout straight from flops. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module trb_out_fifo2 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic             full
);

  logic [WIDTH-1:0] r_head;
  logic [WIDTH-1:0] r_tail;
  logic [1:0]       r_cnt;
  logic             w_push;
  logic             w_pop;

  assign w_pop  = pop && (r_cnt != 2'd0);
  assign w_push = push && ((r_cnt != 2'd2) || w_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head <= '0;
      r_tail <= '0;
      r_cnt  <= 2'd0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          if (r_cnt == 2'd0) r_head <= din;
          else               r_tail <= din;
          r_cnt <= r_cnt + 2'd1;
        end
        2'b01: begin
          r_head <= r_tail;
          r_cnt  <= r_cnt - 2'd1;
        end
        2'b11: begin
          if (r_cnt == 2'd1) begin
            r_head <= din;
          end else begin
            r_head <= r_tail;
            r_tail <= din;
          end
        end
        default: ;
      endcase
    end
  end

  assign dout  = r_head;
  assign valid = (r_cnt != 2'd0);
  assign full  = (r_cnt == 2'd2);

endmodule
`default_nettype wire

// File: rtl/trb_st2bus_pack.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | trb_st2bus_pack                                                            |
// | Packs the decoded 8-bit stream into wide host words with framing recovery. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module trb_st2bus_pack
  import trb_pkg::*;
#(
  parameter int ST        = TRB_ST,
  parameter int OUT_W     = TRB_OUT_W,
  parameter int MAX_BYTES = TRB_BLK_BYTES
) (
  input  logic             clk_st,
  input  logic             rst,
  input  logic [ST-1:0]    st_data_in,
  input  logic             st_valid_in,
  input  logic             st_sop_in,
  input  logic             st_eop_in,
  output logic             st_ready_out,
  output logic [OUT_W-1:0] bus_data_out,
  output logic             bus_valid_out,
  output logic             bus_last_out,
  output logic [6:0]       bus_nbytes_out,
  input  logic             bus_ready_in,
  output logic             err_framing,
  output logic [15:0]      pkt_cnt
);

  localparam int c_LANES  = OUT_W / ST;
  localparam int c_LANE_W = $clog2(c_LANES);
  localparam int c_CNT_W  = $clog2(MAX_BYTES + 1);
  localparam int c_NB_W   = 7;
  localparam int c_FIFO_W = OUT_W + 1 + c_NB_W;

  pack_state_e         r_state, w_state_nx;
  logic [c_LANE_W-1:0] r_lane, w_lane_nx, w_b_lane;
  logic [c_CNT_W-1:0]  r_cnt, w_cnt_nx, w_b_cnt, w_new_cnt;
  logic [OUT_W-1:0]    r_acc, w_acc_nx, w_merged;
  logic                r_pend, w_pend_nx;
  logic                r_err, w_err;
  logic [15:0]         r_pkt_cnt;

  logic                w_take;
  logic                w_full;
  logic                w_at_max;
  logic                w_close;
  logic                w_close_last;
  logic                w_push;
  logic [OUT_W-1:0]    w_push_data;
  logic                w_push_last;
  logic [c_NB_W-1:0]   w_push_nb;
  logic [c_FIFO_W-1:0] w_head;

  // r_pend holds back the stream for one word slot when an sop+eop byte
  // arrives while a partial word must also be flushed in the same cycle.
  assign st_ready_out = ~rst & ~w_full & ~r_pend;
  assign w_take       = st_valid_in & st_ready_out;

  always_comb begin
    w_b_lane  = st_sop_in ? '0 : r_lane;
    w_b_cnt   = st_sop_in ? '0 : r_cnt;
    w_merged  = st_sop_in ? '0 : r_acc;
    w_merged[w_b_lane*ST +: ST] = st_data_in;
    w_new_cnt    = w_b_cnt + c_CNT_W'(1);
    w_at_max     = (w_new_cnt == c_CNT_W'(MAX_BYTES));
    w_close_last = st_eop_in | w_at_max;
    w_close      = w_close_last | (w_b_lane == c_LANE_W'(c_LANES - 1));

    w_state_nx  = r_state;
    w_lane_nx   = r_lane;
    w_cnt_nx    = r_cnt;
    w_acc_nx    = r_acc;
    w_pend_nx   = r_pend;
    w_push      = 1'b0;
    w_push_data = w_merged;
    w_push_last = 1'b0;
    w_push_nb   = c_NB_W'(w_b_lane) + c_NB_W'(1);
    w_err       = 1'b0;

    if (r_pend) begin
      if (!w_full) begin
        w_push      = 1'b1;
        w_push_data = r_acc;
        w_push_last = 1'b1;
        w_push_nb   = c_NB_W'(1);
        w_acc_nx    = '0;
        w_lane_nx   = '0;
        w_cnt_nx    = '0;
        w_pend_nx   = 1'b0;
        w_state_nx  = S_IDLE;
      end
    end else if (w_take) begin
      if (r_state == S_IDLE && !st_sop_in) begin
        w_err = 1'b1;
      end else if (r_state == S_PACK && st_sop_in && r_lane != '0) begin
        // Early sop: flush the partial word as last, restart at lane 0.
        w_err       = 1'b1;
        w_push      = 1'b1;
        w_push_data = r_acc;
        w_push_last = 1'b1;
        w_push_nb   = c_NB_W'(r_lane);
        w_acc_nx    = w_merged;
        w_lane_nx   = c_LANE_W'(1);
        w_cnt_nx    = w_new_cnt;
        w_state_nx  = S_PACK;
        w_pend_nx   = st_eop_in;
      end else begin
        if (r_state == S_PACK && st_sop_in) w_err = 1'b1;
        if (w_close) begin
          w_push      = 1'b1;
          w_push_last = w_close_last;
          w_acc_nx    = '0;
          w_lane_nx   = '0;
          if (w_at_max && !st_eop_in) w_err = 1'b1;
          if (w_close_last) begin
            w_cnt_nx   = '0;
            w_state_nx = S_IDLE;
          end else begin
            w_cnt_nx   = w_new_cnt;
            w_state_nx = S_PACK;
          end
        end else begin
          w_acc_nx   = w_merged;
          w_lane_nx  = w_b_lane + c_LANE_W'(1);
          w_cnt_nx   = w_new_cnt;
          w_state_nx = S_PACK;
        end
      end
    end
  end

  always_ff @(posedge clk_st) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_lane    <= '0;
      r_cnt     <= '0;
      r_acc     <= '0;
      r_pend    <= 1'b0;
      r_err     <= 1'b0;
      r_pkt_cnt <= '0;
    end else begin
      r_state <= w_state_nx;
      r_lane  <= w_lane_nx;
      r_cnt   <= w_cnt_nx;
      r_acc   <= w_acc_nx;
      r_pend  <= w_pend_nx;
      r_err   <= w_err;
      if (w_push && w_push_last) r_pkt_cnt <= r_pkt_cnt + 16'd1;
    end
  end

  trb_out_fifo2 #(
    .WIDTH (c_FIFO_W)
  ) u_fifo (
    .clk   (clk_st),
    .rst   (rst),
    .push  (w_push),
    .din   ({w_push_data, w_push_last, w_push_nb}),
    .pop   (bus_ready_in),
    .dout  (w_head),
    .valid (bus_valid_out),
    .full  (w_full)
  );

  assign bus_data_out   = w_head[c_FIFO_W-1 -: OUT_W];
  assign bus_last_out   = w_head[c_NB_W];
  assign bus_nbytes_out = w_head[c_NB_W-1:0];
  assign err_framing    = r_err;
  assign pkt_cnt        = r_pkt_cnt;

endmodule
`default_nettype wire
